// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// signed or unsigned operands, registered 64-bit product with zero/sign flags.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero_flag,
    output logic                 sign_flag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int         CW      = $clog2(WIDTH + 1);

    logic [1:0]           state_r;
    logic [CW-1:0]        count_r;
    logic [WIDTH+1:0]     acc_r;
    logic [WIDTH+1:0]     mcand_r;
    logic [WIDTH:0]       q_r;
    logic                 q_m1_r;
    logic                 signed_r;

    logic [WIDTH+1:0]     acc_sum_s;
    logic [WIDTH+1:0]     acc_next_s;
    logic [WIDTH:0]       q_next_s;
    logic [2*WIDTH-1:0]   prod_next_s;
    logic [WIDTH+1:0]     ext_mcand_s;
    logic [WIDTH:0]       ext_mplier_s;
    logic                 accept_s;
    logic                 last_step_s;

    // Booth recode of {Q[0],q_m1}, then arithmetic right shift of {A,Q}.
    // A carries a guard bit so A-M cannot overflow for the most negative M.
    always_comb begin
        acc_sum_s = acc_r;
        case ({q_r[0], q_m1_r})
            2'b01:   acc_sum_s = acc_r + mcand_r;
            2'b10:   acc_sum_s = acc_r - mcand_r;
            default: acc_sum_s = acc_r;
        endcase
        acc_next_s   = {acc_sum_s[WIDTH+1], acc_sum_s[WIDTH+1:1]};
        q_next_s     = {acc_sum_s[0], q_r[WIDTH:1]};
        prod_next_s  = {acc_next_s[WIDTH-2:0], q_next_s};
        ext_mcand_s  = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
        ext_mplier_s = {is_signed & multiplier[WIDTH-1], multiplier};
        accept_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_step_s  = (count_r == CW'(WIDTH));
    end

    // Control FSM plus registered status/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            zero_flag <= 1'b0;
            sign_flag <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (accept_s) begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_step_s) begin
                        state_r   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        product   <= prod_next_s;
                        zero_flag <= (prod_next_s == '0);
                        sign_flag <= signed_r & prod_next_s[2*WIDTH-1];
                    end else begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Iteration datapath: operand capture on accept, one Booth step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            q_r      <= '0;
            q_m1_r   <= 1'b0;
            signed_r <= 1'b0;
        end else if (accept_s) begin
            count_r  <= '0;
            acc_r    <= '0;
            mcand_r  <= ext_mcand_s;
            q_r      <= ext_mplier_s;
            q_m1_r   <= 1'b0;
            signed_r <= is_signed;
        end else if (state_r == ST_RUN) begin
            count_r <= count_r + CW'(1);
            acc_r   <= acc_next_s;
            q_r     <= q_next_s;
            q_m1_r  <= q_r[0];
        end else begin
            count_r <= count_r;
        end
    end

endmodule
